// File: rtl/ps2_scancode_decoder_pkg.sv
// ps2_pkg: Set-2 scan code constants, decoder state and event types (Pause ROM under PS2_DECODE_PAUSE_EN)
package ps2_pkg;
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_PAUSE = 8'hE1;
  localparam logic [7:0] PS2_OVR0 = 8'h00;
  localparam logic [7:0] PS2_OVR1 = 8'hFF;
  typedef enum logic [2:0] {
    IDLE, EXT, BRK, EXT_BRK
`ifdef PS2_DECODE_PAUSE_EN
    , PAUSE
`endif
  } state_t;
  typedef struct packed {
    logic [7:0] code;
    logic brk;
    logic ext;
    logic pause;
  } ps2_event_t;
`ifdef PS2_DECODE_PAUSE_EN
  // bytes that must follow the leading E1 of the Pause make sequence
  localparam logic [0:6][7:0] PS2_PAUSE_SEQ = {8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
`endif
  function automatic logic is_prefix(input logic [7:0] b);
    return b == PS2_EXT || b == PS2_BRK;
  endfunction
endpackage

// File: rtl/ps2_scancode_decoder_if.sv
// ps2_scancode_decoder_if: receiver byte stream in, key event valid/ready stream out
interface ps2_scancode_decoder_if;
  logic [7:0] rx_data;
  logic rx_ready;
  logic rx_valid;
  logic ev_valid;
  logic ev_ready;
  logic [7:0] ev_code;
  logic ev_break;
  logic ev_ext;
  logic ev_pause;
  modport master (
    input rx_data, rx_ready, rx_valid, ev_ready,
    output ev_valid, ev_code, ev_break, ev_ext, ev_pause
  );
  modport slave (
    output rx_data, rx_ready, rx_valid, ev_ready,
    input ev_valid, ev_code, ev_break, ev_ext, ev_pause
  );
endinterface

// File: rtl/ps2_scancode_decoder_fifo.sv
// ps2_event_fifo: first-word-fall-through FIFO of key events with flush and occupancy
module ps2_event_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input logic clk,
  input logic rst_n,
  input logic flush,
  input logic push,
  input logic pop,
  input ps2_event_t din,
  output ps2_event_t head,
  output logic full,
  output logic empty,
  output logic [AW:0] level
);
  ps2_event_t mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign rd = pop & ~empty & ~flush;
  // a pop frees the slot a same-cycle push into a full FIFO needs
  assign wr = push & (~full | rd) & ~flush;
  assign head = empty ? '0 : mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else if (flush) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      level <= level + LW'(wr) - LW'(rd);
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
endmodule

// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set-2 scan codes to key events; Pause sequence decode under PS2_DECODE_PAUSE_EN
module ps2_scancode_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int ERR_W = 8
) (
  input logic clk,
  input logic rst_n,
  ps2_scancode_decoder_if.master bus,
  input logic flush,
  input logic ovf_clr,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic ovf,
  output logic [ERR_W-1:0] err_count
);
  state_t st, st_n;
  logic prev, stb, vld, push, err, full, empty, drop;
  logic [7:0] dat;
  ps2_event_t ev, head;
`ifdef PS2_DECODE_PAUSE_EN
  logic [2:0] idx, idx_n;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) idx <= '0;
    else idx <= idx_n;
`endif
  // bytes are registered with the edge strobe, so decode runs one cycle after rx_ready rises
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      prev <= 1'b0;
      stb <= 1'b0;
      vld <= 1'b0;
      dat <= '0;
      st <= IDLE;
      err_count <= '0;
      ovf <= 1'b0;
    end else begin
      prev <= bus.rx_ready;
      stb <= bus.rx_ready & ~prev;
      vld <= bus.rx_valid;
      dat <= bus.rx_data;
      st <= st_n;
      err_count <= err_count + ERR_W'(err & ~&err_count);
      ovf <= drop | (ovf & ~ovf_clr);
    end
  always_comb begin
    st_n = st;
    push = 1'b0;
    err = 1'b0;
    ev = '{code: dat, default: '0};
`ifdef PS2_DECODE_PAUSE_EN
    idx_n = idx;
`endif
    if (stb) begin
      if (!vld || dat == PS2_OVR0 || dat == PS2_OVR1) begin
        st_n = IDLE;
        err = 1'b1;
      end else
        case (st)
          IDLE:
            if (dat == PS2_EXT) st_n = EXT;
            else if (dat == PS2_BRK) st_n = BRK;
`ifdef PS2_DECODE_PAUSE_EN
            else if (dat == PS2_PAUSE) begin
              st_n = PAUSE;
              idx_n = '0;
            end
`endif
            else push = 1'b1;
          EXT:
            if (dat == PS2_BRK) st_n = EXT_BRK;
            else if (dat != PS2_EXT) begin
              push = 1'b1;
              ev.ext = 1'b1;
              st_n = IDLE;
            end
          BRK, EXT_BRK: begin
            st_n = IDLE;
            err = is_prefix(dat);
            push = ~is_prefix(dat);
            ev.brk = 1'b1;
            ev.ext = st == EXT_BRK;
          end
`ifdef PS2_DECODE_PAUSE_EN
          PAUSE:
            if (dat != PS2_PAUSE_SEQ[idx]) begin
              err = 1'b1;
              st_n = IDLE;
            end else if (idx == 3'd6) begin
              push = 1'b1;
              ev.pause = 1'b1;
              st_n = IDLE;
            end else idx_n = idx + 3'd1;
`endif
          default: st_n = IDLE;
        endcase
    end
    if (flush) begin
      st_n = IDLE;
      push = 1'b0;
      err = 1'b0;
    end
  end
  assign drop = push & full & ~bus.ev_ready;
  ps2_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .push(push),
    .pop(bus.ev_ready),
    .din(ev),
    .head(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign bus.ev_valid = ~empty;
  assign bus.ev_code = head.code;
  assign bus.ev_break = head.brk;
  assign bus.ev_ext = head.ext;
`ifdef PS2_DECODE_PAUSE_EN
  assign bus.ev_pause = head.pause;
`else
  logic unused_pause;
  assign unused_pause = head.pause;
  assign bus.ev_pause = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed scenario tests for the Set-2 scan code decoder
module tb_ps2_scancode_decoder;
`ifdef PS2_DECODE_PAUSE_EN
  localparam int PE = 1;
`else
  localparam int PE = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  logic ovf_clr = 1'b0;
  logic [3:0] fifo_level;
  logic ovf;
  logic [7:0] err_count;
  int checks = 0;
  int errors = 0;
  ps2_scancode_decoder_if bus ();
  ps2_scancode_decoder #(.FIFO_DEPTH(8), .ERR_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .flush(flush),
    .ovf_clr(ovf_clr),
    .fifo_level(fifo_level),
    .ovf(ovf),
    .err_count(err_count)
  );
  always #5 clk = ~clk;
  wire [11:0] evw = {bus.ev_valid, bus.ev_code, bus.ev_break, bus.ev_ext, bus.ev_pause};

  task automatic send(input logic [7:0] b, input logic v = 1'b1);
    @(negedge clk);
    bus.rx_data = b;
    bus.rx_valid = v;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic pop();
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.ev_ready = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({evw, fifo_level, ovf, err_count} !== 25'd0) begin
      errors++;
      $display("FAIL reset: got %h want 0", {evw, fifo_level, ovf, err_count});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_make_break();
    send(8'h1C);
    checks++;
    if (evw !== {1'b1, 8'h1C, 3'b000}) begin errors++; $display("FAIL make_1c: got %h want %h", evw, {1'b1, 8'h1C, 3'b000}); end
    pop();
    send(8'hF0);
    send(8'h1C);
    checks++;
    if (evw !== {1'b1, 8'h1C, 3'b100}) begin errors++; $display("FAIL break_1c: got %h want %h", evw, {1'b1, 8'h1C, 3'b100}); end
    pop();
    checks++;
    if ({bus.ev_valid, err_count} !== 9'd0) begin errors++; $display("FAIL make_break_tail: got %h want 0", {bus.ev_valid, err_count}); end
  endtask

  task automatic test_ext();
    send(8'hE0);
    send(8'h75);
    checks++;
    if (evw !== {1'b1, 8'h75, 3'b010}) begin errors++; $display("FAIL ext_make: got %h want %h", evw, {1'b1, 8'h75, 3'b010}); end
    pop();
    send(8'hE0);
    send(8'hF0);
    send(8'h75);
    checks++;
    if (evw !== {1'b1, 8'h75, 3'b110}) begin errors++; $display("FAIL ext_break: got %h want %h", evw, {1'b1, 8'h75, 3'b110}); end
    pop();
  endtask

  task automatic test_pause();
    logic [7:0] seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
`ifdef PS2_DECODE_PAUSE_EN
    foreach (seq[i]) begin
      send(seq[i]);
      if (i < 7) begin
        checks++;
        if (bus.ev_valid !== 1'b0) begin errors++; $display("FAIL pause_early: byte %0d got valid %b want 0", i, bus.ev_valid); end
      end
    end
    checks++;
    if ({evw, fifo_level} !== {1'b1, 8'h77, 3'b001, 4'd1}) begin errors++; $display("FAIL pause_event: got %h want %h", {evw, fifo_level}, {1'b1, 8'h77, 3'b001, 4'd1}); end
    pop();
    for (int i = 0; i < 4; i++) send(i == 3 ? 8'h12 : seq[i]);
    checks++;
    if ({bus.ev_valid, err_count} !== {1'b0, 8'd1}) begin errors++; $display("FAIL pause_mismatch: got %h want %h", {bus.ev_valid, err_count}, {1'b0, 8'd1}); end
    send(8'h1C);
    checks++;
    if (evw !== {1'b1, 8'h1C, 3'b000}) begin errors++; $display("FAIL pause_recover: got %h want %h", evw, {1'b1, 8'h1C, 3'b000}); end
    pop();
`else
    send(seq[0]);
    checks++;
    if (evw !== {1'b1, 8'hE1, 3'b000}) begin errors++; $display("FAIL e1_plain: got %h want %h", evw, {1'b1, 8'hE1, 3'b000}); end
    pop();
    send(seq[1]);
    checks++;
    if ({evw, err_count} !== {1'b1, 8'h14, 3'b000, 8'd0}) begin errors++; $display("FAIL e1_follow: got %h want %h", {evw, err_count}, {1'b1, 8'h14, 3'b000, 8'd0}); end
    pop();
`endif
  endtask

  task automatic test_invalid();
    send(8'hF0);
    send(8'h1C, 1'b0);
    checks++;
    if ({bus.ev_valid, err_count} !== {1'b0, 8'(PE + 1)}) begin errors++; $display("FAIL invalid_byte: got %h want %h", {bus.ev_valid, err_count}, {1'b0, 8'(PE + 1)}); end
    send(8'h1C);
    checks++;
    if (evw !== {1'b1, 8'h1C, 3'b000}) begin errors++; $display("FAIL invalid_recover: got %h want %h", evw, {1'b1, 8'h1C, 3'b000}); end
    pop();
  endtask

  task automatic test_overrun();
    send(8'hE0);
    send(8'h00);
    send(8'hF0);
    send(8'hFF);
    checks++;
    if ({bus.ev_valid, err_count} !== {1'b0, 8'(PE + 3)}) begin errors++; $display("FAIL overrun_err: got %h want %h", {bus.ev_valid, err_count}, {1'b0, 8'(PE + 3)}); end
    send(8'h75);
    checks++;
    if (evw !== {1'b1, 8'h75, 3'b000}) begin errors++; $display("FAIL overrun_recover: got %h want %h", evw, {1'b1, 8'h75, 3'b000}); end
    pop();
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 10; i++) send(8'h10 + 8'(i));
    checks++;
    if ({fifo_level, ovf} !== {4'd8, 1'b1}) begin errors++; $display("FAIL ovf_fill: got %h want %h", {fifo_level, ovf}, {4'd8, 1'b1}); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (evw !== {1'b1, 8'h10 + 8'(i), 3'b000}) begin errors++; $display("FAIL ovf_order %0d: got %h want %h", i, evw, {1'b1, 8'h10 + 8'(i), 3'b000}); end
      pop();
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++;
    if ({bus.ev_valid, ovf} !== 2'b00) begin errors++; $display("FAIL ovf_clr: got %b want 00", {bus.ev_valid, ovf}); end
  endtask

  task automatic test_full_pop();
    for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
    @(negedge clk);
    bus.rx_data = 8'h28;
    bus.rx_valid = 1'b1;
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
    bus.ev_ready = 1'b1;
    @(negedge clk);
    bus.ev_ready = 1'b0;
    checks++;
    if ({fifo_level, ovf, bus.ev_code} !== {4'd8, 1'b0, 8'h21}) begin errors++; $display("FAIL full_pop: got %h want %h", {fifo_level, ovf, bus.ev_code}, {4'd8, 1'b0, 8'h21}); end
  endtask

  task automatic test_flush();
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if ({bus.ev_valid, fifo_level} !== 5'd0) begin errors++; $display("FAIL flush_empty: got %h want 0", {bus.ev_valid, fifo_level}); end
    send(8'hE0);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    send(8'h75);
    checks++;
    if (evw !== {1'b1, 8'h75, 3'b000}) begin errors++; $display("FAIL flush_idle: got %h want %h", evw, {1'b1, 8'h75, 3'b000}); end
    pop();
  endtask

  task automatic test_hold();
    @(negedge clk);
    bus.rx_data = 8'h1C;
    bus.rx_valid = 1'b1;
    bus.rx_ready = 1'b1;
    repeat (5) @(negedge clk);
    bus.rx_ready = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({fifo_level, evw} !== {4'd1, 1'b1, 8'h1C, 3'b000}) begin errors++; $display("FAIL hold_once: got %h want %h", {fifo_level, evw}, {4'd1, 1'b1, 8'h1C, 3'b000}); end
    pop();
  endtask

  task automatic test_reset_mid();
    send(8'h1C);
    send(8'hE0);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({evw, fifo_level, ovf, err_count} !== 25'd0) begin errors++; $display("FAIL reset_mid: got %h want 0", {evw, fifo_level, ovf, err_count}); end
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h75);
    checks++;
    if (evw !== {1'b1, 8'h75, 3'b000}) begin errors++; $display("FAIL reset_ext_cleared: got %h want %h", evw, {1'b1, 8'h75, 3'b000}); end
    pop();
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 260; i++) send(8'h1C, 1'b0);
    checks++;
    if ({bus.ev_valid, err_count} !== {1'b0, 8'hFF}) begin errors++; $display("FAIL err_saturate: got %h want %h", {bus.ev_valid, err_count}, {1'b0, 8'hFF}); end
  endtask

  initial begin
    bus.rx_data = 8'h00;
    bus.rx_ready = 1'b0;
    bus.rx_valid = 1'b0;
    bus.ev_ready = 1'b0;
    #1;
    test_reset();
    test_make_break();
    test_ext();
    test_pause();
    test_invalid();
    test_overrun();
    test_overflow();
    test_full_pop();
    test_flush();
    test_hold();
    test_reset_mid();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes the byte stream from the PS/2 receive stage (8-bit data with single-cycle ready pulse and valid flag) and turns Set-2 keyboard scan codes into key events. Tracks the E0 (extended) and F0 (break) prefixes and optionally the 8-byte Pause sequence. Queues events in a small first-word-fall-through FIFO with a valid/ready handshake toward the host-side consumer. Sits directly downstream of the PS/2 byte receiver, in the same `clk` domain.

## Interface
- FIFO_DEPTH, 8, event FIFO depth; power of two, 2..64
- ERR_W, 8, width of saturating error counter
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  8  byte from receiver
- rx_ready  in  1  byte-available pulse from receiver
- rx_valid  in  1  framing/parity OK for rx_data; qualified by rx_ready
- flush  in  1  synchronous: empties FIFO, returns FSM to IDLE
- ev_valid  out  1  FIFO head holds an event
- ev_ready  in  1  consumer accepts head when ev_valid & ev_ready
- ev_code  out  8  key code (prefixes stripped)
- ev_break  out  1  1 = key release
- ev_ext  out  1  1 = E0-prefixed key
- ev_pause  out  1  1 = Pause key event (0 when feature compiled out)
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- ovf  out  1  sticky: an event was dropped because FIFO was full
- ovf_clr  in  1  synchronous clear of ovf
- err_count  out  ERR_W  saturating count of discarded bytes/sequences

## Operation
- Byte strobe: byte accepted in the cycle where rx_ready=1 and rx_ready was 0 in the previous cycle (registered edge detect). A level held high counts once.
- rx_valid=0 on accepted byte: byte discarded, FSM -> IDLE, err_count+1.
- 0x00 or 0xFF in any state: keyboard overrun; discarded, FSM -> IDLE, err_count+1.
- FSM states: IDLE, EXT, BRK, EXT_BRK, PAUSE.
  - IDLE: E0 -> EXT; F0 -> BRK; E1 -> PAUSE (feature on); other -> push {code, break=0, ext=0}, stay IDLE.
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> push {code, 0, 1}, -> IDLE.
  - BRK: any non-prefix -> push {code, 1, 0}, -> IDLE; E0/F0 in BRK -> error, discard, -> IDLE.
  - EXT_BRK: non-prefix -> push {code, 1, 1}, -> IDLE; prefix -> error, -> IDLE.
  - PAUSE: 3-bit index compares remaining 7 bytes against 14 77 E1 F0 14 F0 77. On 7th match, push {0x77, 0, 0, pause=1}, -> IDLE. On mismatch, discard, err_count+1, -> IDLE (mismatching byte not reinterpreted).
- err_count saturates at all-ones; cleared only by reset.
- FIFO push when full: event dropped, ovf set. If pop occurs in the same cycle as a push when full, the push is accepted.
- flush same cycle as push: flush wins; FIFO empty, FSM IDLE next cycle. ovf is unaffected by flush.
- ovf_clr and a new overflow in the same cycle: ovf stays 1.

## Timing
- Reset values: ev_valid=0, ev_code=0, ev_break=0, ev_ext=0, ev_pause=0, fifo_level=0, ovf=0, err_count=0; FSM IDLE; edge-detect register 0.
- Latency: rx_ready rises in cycle N -> event written at end of N+1 (edge-detect register) -> ev_valid=1 in N+2 if FIFO was empty.
- ev_* fields reflect the FIFO head combinationally from registered storage; they are stable while ev_valid=1 and no pop occurs.
- Throughput: one event per cycle on both push and pop.

## Configuration
- PS2_DECODE_PAUSE_EN defined: PAUSE state and comparison ROM built; E1 starts Pause sequence.
- Undefined: no PAUSE state; E1 treated as an ordinary code (pushed as make 0xE1); following bytes decode normally; ev_pause tied 0.

## Structure
- Package ps2_pkg: Set-2 constants (PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, overrun codes), FSM state enum, packed event struct {code, brk, ext, pause}, Pause sequence constant array.
- Sub-module ps2_event_fifo: parameterised FWFT FIFO of the event struct with push, pop, flush, full, empty and level outputs; the decoder instantiates it once.

## Test plan
- Bytes 1C then F0 1C (valid) -> events {1C,brk0,ext0} then {1C,brk1,ext0}; err_count=0.
- E0 75, then E0 F0 75 -> {75,0,ext1} then {75,brk1,ext1}.
- Pause sequence E1 14 77 E1 F0 14 F0 77 with macro defined -> one event {77,0,0,pause1}. Repeat with 4th byte 0x12 -> no event, err_count=1, next 1C decodes normally.
- Byte with rx_valid=0 after F0 -> discarded, err_count+1; following 1C -> make event (break state cleared).
- ev_ready held 0, 10 make codes with FIFO_DEPTH=8 -> fifo_level=8, ovf=1, first 8 codes read in order after ev_ready=1; ovf_clr -> ovf=0.
- rx_ready held high 5 cycles for one byte -> exactly one event; assert rst_n low mid-sequence after E0 -> all outputs at reset values, next 75 decodes with ext=0.
